cap_seq: RTL

//  Capture sequencer between the trigger unit and the SRAM address generator.

---
 rtl/cap_seq_pkg.sv | 18 +
 rtl/cap_seq_sat_cnt.sv | 40 ++++
 rtl/cap_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cap_seq_pkg.sv
// Shared definitions for the capture sequencer. The state encodings are also
// used by the status readback, so their values are fixed.
package cap_seq_pkg;

    typedef enum logic [2:0] {
        CS_IDLE  = 3'd0,
        CS_PRE   = 3'd1,
        CS_ARMED = 3'd2,
        CS_POST  = 3'd3,
        CS_DONE  = 3'd4
    } cap_state_e;

    // States in which an incoming sample strobe may reach the SRAM.
    function automatic logic cs_writes(input cap_state_e s);
        return (s == CS_PRE) || (s == CS_ARMED) || (s == CS_POST);
    endfunction

endpackage

// File: rtl/cap_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear. hit_o flags that the count is
// at the limit, or reaches it with the increment taken this cycle.
module cap_seq_sat_cnt #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         hit_o
);
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q, cnt_d;
    logic         at_lim;

    always_comb begin
        at_lim = (cnt_q == limit_i);
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !at_lim) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = at_lim || (en_i && ((cnt_q + ONE) == limit_i));

endmodule

// File: rtl/cap_seq.sv
// Capture sequencer: gates sample writes into the SRAM ring, tracks pre/post
// trigger depth and reports the trigger-anchored read window.
module cap_seq
    import cap_seq_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              run,
    input  logic              smpl_wr,
    input  logic              trig_pulse,
    input  logic              trig_force,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [ADDR_W-1:0] post_len,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] rd_start,
    output logic [ADDR_W-1:0] pre_kept,
    output logic              armed,
    output logic              cap_done
);
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    cap_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] pre_len_q, pre_len_d;
    logic [ADDR_W-1:0] post_len_q, post_len_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] pre_kept_q, pre_kept_d;
    logic              pend_q, pend_d;

    logic              in_idle, in_pre, in_armed, in_post;
    logic              wr_ok, trig_hit;
    logic [ADDR_W-1:0] pre_cnt, post_cnt, kept_max;
    logic              pre_hit, post_hit;
    logic              unused_post_cnt;

    assign in_idle  = (state_q == CS_IDLE);
    assign in_pre   = (state_q == CS_PRE);
    assign in_armed = (state_q == CS_ARMED);
    assign in_post  = (state_q == CS_POST);

    // A zero-length pre phase is a single idle cycle with no writes.
    assign wr_ok    = run && smpl_wr && cs_writes(state_q) && !(in_pre && (pre_len_q == '0));
    assign trig_hit = wr_ok && ((in_pre   && (pend_q || trig_force)) ||
                                (in_armed && (pend_q || trig_pulse || trig_force)));
    // Ring holds trigger + post samples, leaving 2**ADDR_W-1-post_len slots for history.
    assign kept_max = ~post_len_q;

    cap_seq_sat_cnt #(.W(ADDR_W)) u_pre_cnt (
        .clk     (clk),
        .nrst    (nrst),
        .clr_i   (in_idle),
        .en_i    (wr_ok && (in_pre || in_armed)),
        .limit_i (pre_len_q),
        .cnt_o   (pre_cnt),
        .hit_o   (pre_hit)
    );

    cap_seq_sat_cnt #(.W(ADDR_W)) u_post_cnt (
        .clk     (clk),
        .nrst    (nrst),
        .clr_i   (in_idle || trig_hit),
        .en_i    (wr_ok && in_post),
        .limit_i (post_len_q),
        .cnt_o   (post_cnt),
        .hit_o   (post_hit)
    );

    assign unused_post_cnt = ^post_cnt;

    always_comb begin
        state_d     = state_q;
        ptr_d       = wr_ok ? (ptr_q + ONE) : ptr_q;
        pend_d      = pend_q;
        pre_len_d   = pre_len_q;
        post_len_d  = post_len_q;
        trig_addr_d = trig_addr_q;
        pre_kept_d  = pre_kept_q;

        case (state_q)
            CS_IDLE: begin
                pend_d = 1'b0;
                if (run) begin
                    state_d    = CS_PRE;
                    ptr_d      = '0;
                    pre_len_d  = pre_len;
                    post_len_d = post_len;
                end
            end
            CS_PRE: begin
                if (!trig_hit) begin
                    pend_d = pend_q || trig_force;
                    if (pre_hit) begin
                        state_d = CS_ARMED;
                    end
                end
            end
            CS_ARMED: begin
                if (!trig_hit) begin
                    pend_d = pend_q || trig_pulse || trig_force;
                end
            end
            CS_POST: begin
                if (post_hit) begin
                    state_d = CS_DONE;
                end
            end
            CS_DONE: begin
                pend_d = 1'b0;
            end
            default: begin
                state_d = CS_IDLE;
            end
        endcase

        if (trig_hit) begin
            trig_addr_d = ptr_q;
            pre_kept_d  = (pre_cnt > kept_max) ? kept_max : pre_cnt;
            pend_d      = 1'b0;
            state_d     = (post_len_q == '0) ? CS_DONE : CS_POST;
        end

        // Stopping overrides everything; the trigger window is kept for readout.
        if (!run) begin
            state_d = CS_IDLE;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= CS_IDLE;
            ptr_q       <= '0;
            pend_q      <= 1'b0;
            pre_len_q   <= '0;
            post_len_q  <= '0;
            trig_addr_q <= '0;
            pre_kept_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            pre_len_q   <= pre_len_d;
            post_len_q  <= post_len_d;
            trig_addr_q <= trig_addr_d;
            pre_kept_q  <= pre_kept_d;
        end
    end

    assign wr_en     = wr_ok;
    assign wr_addr   = ptr_q;
    assign trig_addr = trig_addr_q;
    assign pre_kept  = pre_kept_q;
    assign rd_start  = trig_addr_q - pre_kept_q;
    assign armed     = in_armed;
    assign cap_done  = (state_q == CS_DONE);

endmodule
